// File: rtl/vga_rect_plotter.sv
// vga_rect_plotter
//   Rectangle raster engine for the DESim VGA pixel interface. A command
//   (position, size, colour, mode) is latched on start. It is clipped against
//   the H_RES x V_RES screen and then scanned in row-major order, one pixel
//   per clock.
//
// Ports
//   CLOCK_50           rising-edge system clock
//   reset              synchronous, active-high reset
//   start              command strobe, honoured only when idle
//   mode               0 fill, 1 clear screen, 2 outline, 3 fill
//   x0, y0             top-left corner of the rectangle
//   width, height      rectangle size in pixels
//   color              draw colour
//   busy               command in progress
//   done               one-cycle completion pulse
//   VGA_X, VGA_Y       current pixel coordinate
//   VGA_COLOR          current pixel colour
//   plot               pixel write strobe
module vga_rect_plotter #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 24
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W:0]       width,
    input  logic [Y_W:0]       height,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     VGA_X,
    output logic [Y_W-1:0]     VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot
);

    typedef enum logic [1:0] {IDLE, CLIP, DRAW, DONE} state_t;

    localparam logic [X_W:0]   H_LIM  = (X_W+1)'(H_RES);
    localparam logic [Y_W:0]   V_LIM  = (Y_W+1)'(V_RES);
    localparam logic [X_W:0]   X_ONE  = (X_W+1)'(1);
    localparam logic [Y_W:0]   Y_ONE  = (Y_W+1)'(1);
    localparam logic [X_W-1:0] X_STEP = X_W'(1);
    localparam logic [Y_W-1:0] Y_STEP = Y_W'(1);

    state_t state, state_next;

    // Latched command.
    logic [X_W-1:0]     cmd_x0;
    logic [Y_W-1:0]     cmd_y0;
    logic [X_W:0]       cmd_w;
    logic [Y_W:0]       cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               outline;

    // Clipped scan limits and scan counters.
    logic [X_W:0]       x_last;
    logic [Y_W:0]       y_last;
    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;

    logic [X_W:0]       x_room, x_end, x_off;
    logic [Y_W:0]       y_room, y_end, y_off;
    logic               empty, edge_hit, x_wrap, y_wrap;

    logic               busy_next, done_next, plot_next;
    logic [X_W-1:0]     vga_x_next;
    logic [Y_W-1:0]     vga_y_next;
    logic [COLOR_W-1:0] vga_color_next;

    // Clipping is done as "width > room left on screen" rather than by adding
    // first, so x0+width can never wrap the X_W+1 bit arithmetic. The room
    // value is garbage when x0 >= H_RES, but that case is rejected as empty.
    always_comb begin
        x_room   = H_LIM - {1'b0, cmd_x0};
        y_room   = V_LIM - {1'b0, cmd_y0};
        x_end    = (cmd_w > x_room) ? H_LIM : ({1'b0, cmd_x0} + cmd_w);
        y_end    = (cmd_h > y_room) ? V_LIM : ({1'b0, cmd_y0} + cmd_h);
        empty    = (cmd_w == '0) || (cmd_h == '0) ||
                   ({1'b0, cmd_x0} >= H_LIM) || ({1'b0, cmd_y0} >= V_LIM);

        // Far edges are found from the offset into the rectangle against the
        // unclipped size, so a clipped edge never matches and nothing wraps.
        x_off    = {1'b0, x_cnt} - {1'b0, cmd_x0};
        y_off    = {1'b0, y_cnt} - {1'b0, cmd_y0};
        edge_hit = (x_cnt == cmd_x0) || (x_off == cmd_w - X_ONE) ||
                   (y_cnt == cmd_y0) || (y_off == cmd_h - Y_ONE);

        x_wrap   = ({1'b0, x_cnt} == x_last);
        y_wrap   = ({1'b0, y_cnt} == y_last);
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        plot_next      = 1'b0;
        vga_x_next     = VGA_X;
        vga_y_next     = VGA_Y;
        vga_color_next = VGA_COLOR;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLIP;
                    busy_next  = 1'b1;
                end
            end
            CLIP: begin
                busy_next  = 1'b1;
                state_next = empty ? DONE : DRAW;
            end
            DRAW: begin
                busy_next      = 1'b1;
                plot_next      = !outline || edge_hit;
                vga_x_next     = x_cnt;
                vga_y_next     = y_cnt;
                vga_color_next = cmd_color;
                if (x_wrap && y_wrap) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
        end else begin
            state     <= state_next;
            busy      <= busy_next;
            done      <= done_next;
            plot      <= plot_next;
            VGA_X     <= vga_x_next;
            VGA_Y     <= vga_y_next;
            VGA_COLOR <= vga_color_next;
        end
    end

    // NOTE: the command and scan registers have no reset. Each one is loaded
    // in IDLE or CLIP before DRAW reads it, so its power-up value is never seen.
    always_ff @(posedge CLOCK_50) begin
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode == 2'd1) begin
                        cmd_x0 <= '0;
                        cmd_y0 <= '0;
                        cmd_w  <= H_LIM;
                        cmd_h  <= V_LIM;
                    end else begin
                        cmd_x0 <= x0;
                        cmd_y0 <= y0;
                        cmd_w  <= width;
                        cmd_h  <= height;
                    end
                    cmd_color <= color;
                    outline   <= (mode == 2'd2);
                end
            end
            CLIP: begin
                x_last <= x_end - X_ONE;
                y_last <= y_end - Y_ONE;
                x_cnt  <= cmd_x0;
                y_cnt  <= cmd_y0;
            end
            DRAW: begin
                if (x_wrap) begin
                    x_cnt <= cmd_x0;
                    y_cnt <= y_cnt + Y_STEP;
                end else begin
                    x_cnt <= x_cnt + X_STEP;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// tb_vga_rect_plotter
//   Bench for vga_rect_plotter. It drives a 640x480 instance from a table of
//   commands and scoreboards every plotted pixel. A 160x120 instance is used
//   for the full clear-screen command.
module tb_vga_rect_plotter;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int SH = 160;
    localparam int SV = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [1:0]  mode;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [10:0] width;
    logic [9:0]  height;
    logic [23:0] color;
    logic        busy, done, plot;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic [23:0] vga_color;

    logic        s_start;
    logic [1:0]  s_mode;
    logic [7:0]  s_x0;
    logic [6:0]  s_y0;
    logic [8:0]  s_width;
    logic [7:0]  s_height;
    logic [2:0]  s_color;
    logic        s_busy, s_done, s_plot;
    logic [7:0]  s_vga_x;
    logic [6:0]  s_vga_y;
    logic [2:0]  s_vga_color;

    vga_rect_plotter dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .width(width), .height(height), .color(color),
        .busy(busy), .done(done), .VGA_X(vga_x), .VGA_Y(vga_y),
        .VGA_COLOR(vga_color), .plot(plot)
    );

    vga_rect_plotter #(
        .H_RES(SH), .V_RES(SV), .X_W(8), .Y_W(7), .COLOR_W(3)
    ) dut_small (
        .CLOCK_50(clk), .reset(reset), .start(s_start), .mode(s_mode),
        .x0(s_x0), .y0(s_y0), .width(s_width), .height(s_height), .color(s_color),
        .busy(s_busy), .done(s_done), .VGA_X(s_vga_x), .VGA_Y(s_vga_y),
        .VGA_COLOR(s_vga_color), .plot(s_plot)
    );

    typedef struct {
        logic [1:0]  mode;
        int          x0, y0, w, h;
        logic [23:0] color;
        int          exp_plots;  // plot strobes expected
        int          exp_done;   // cycles from start edge to done
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the whole unclipped rectangle, keep on-screen pixels and,
    // for outline, only those on the unclipped border.
    task automatic build_expected(input vec_t v);
        int rx0, ry0, rw, rh;
        bit on_edge;
        rx0 = v.x0; ry0 = v.y0; rw = v.w; rh = v.h;
        if (v.mode == 2'd1) begin
            rx0 = 0; ry0 = 0; rw = H; rh = V;
        end
        for (int y = ry0; y < ry0 + rh; y++) begin
            for (int x = rx0; x < rx0 + rw; x++) begin
                if (x < H && y < V) begin
                    on_edge = (x == rx0) || (x == rx0 + rw - 1) ||
                              (y == ry0) || (y == ry0 + rh - 1);
                    if (v.mode != 2'd2 || on_edge)
                        exp_q.push_back('{x, y, int'(v.color)});
                end
            end
        end
    endtask

    // inject: 0 none, 1 stray start at cycle 3, 2 reset at cycle 3.
    // Cycle c is sampled 1 ns after the c-th edge following the start edge.
    task automatic run_cmd(input vec_t v, input int inject, input string tag,
                           output int done_at, output int plots,
                           output int first, output int busy_n);
        pix_t e;
        build_expected(v);
        mode   = v.mode;
        x0     = 10'(v.x0);
        y0     = 9'(v.y0);
        width  = 11'(v.w);
        height = 10'(v.h);
        color  = v.color;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        done_at = -1;
        plots   = 0;
        first   = -1;
        busy_n  = 0;
        for (int c = 0; c <= v.exp_done + 10; c++) begin
            if (c > 0) tick();
            if (inject == 2 && c == 4) begin
                check({tag, " plot after reset"}, int'(plot), 0);
                check({tag, " busy after reset"}, int'(busy), 0);
                check({tag, " done after reset"}, int'(done), 0);
                reset = 1'b0;
                break;
            end
            if (plot) begin
                check({tag, " x on screen"}, int'(vga_x < 10'(H)), 1);
                check({tag, " y on screen"}, int'(vga_y < 9'(V)), 1);
                if (exp_q.size() == 0) begin
                    check({tag, " unexpected plot"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " x"}, int'(vga_x), e.x);
                    check({tag, " y"}, int'(vga_y), e.y);
                    check({tag, " color"}, int'(vga_color), e.c);
                end
                plots++;
                if (first < 0) first = c;
            end
            if (busy) busy_n++;
            if (done) begin
                done_at = c;
                break;
            end
            if (inject == 1 && c == 3) begin
                start = 1'b1; mode = 2'd0; x0 = 10'd300; y0 = 9'd300;
                width = 11'd5; height = 10'd5; color = 24'h00FF00;
            end
            if (inject == 1 && c == 4) start = 1'b0;
            if (inject == 2 && c == 3) reset = 1'b1;
        end
    endtask

    // Watch an idle DUT; any activity is counted.
    task automatic watch_idle(input int cycles, output int activity);
        activity = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (plot || busy || done) activity++;
        end
    endtask

    vec_t vecs[10];
    int   done_at, plots, first, busy_n, act;
    string tag;

    initial begin
        vecs[0] = '{2'd0,  10,   5,    3,   2, 24'hFF0000,  6,  8};  // fill
        vecs[1] = '{2'd0, 638, 478,    5,   4, 24'h0000FF,  4,  6};  // clip corner
        vecs[2] = '{2'd0,  10,   5,    0,   2, 24'h123456,  0,  2};  // width 0
        vecs[3] = '{2'd0, 700,   5,    3,   2, 24'h123456,  0,  2};  // x0 off screen
        vecs[4] = '{2'd2,   0,   0,    4,   3, 24'hABCDEF, 10, 14};  // outline
        vecs[5] = '{2'd0,  10,   5,    3,   0, 24'h123456,  0,  2};  // height 0
        vecs[6] = '{2'd0,  10, 480,    3,   2, 24'h123456,  0,  2};  // y0 off screen
        vecs[7] = '{2'd2, 637,  10,    6,   3, 24'h00FFFF,  7, 11};  // clipped outline
        vecs[8] = '{2'd3, 100, 200,    2,   2, 24'h0F0F0F,  4,  6};  // reserved mode
        vecs[9] = '{2'd0, 600,   0, 2047,   1, 24'h777777, 40, 42};  // huge width

        reset = 1'b1; start = 1'b0; mode = '0; x0 = '0; y0 = '0;
        width = '0; height = '0; color = '0;
        s_start = 1'b0; s_mode = '0; s_x0 = '0; s_y0 = '0;
        s_width = '0; s_height = '0; s_color = '0;
        repeat (3) tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset plot", int'(plot), 0);
        check("reset vga_x", int'(vga_x), 0);
        check("reset vga_y", int'(vga_y), 0);
        check("reset vga_color", int'(vga_color), 0);
        check("small reset busy", int'(s_busy), 0);
        check("small reset plot", int'(s_plot), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            tag = $sformatf("vec%0d", i);
            run_cmd(vecs[i], 0, tag, done_at, plots, first, busy_n);
            check({tag, " done cycle"}, done_at, vecs[i].exp_done);
            check({tag, " plot count"}, plots, vecs[i].exp_plots);
            check({tag, " pixels left"}, exp_q.size(), 0);
            check({tag, " first plot cycle"}, first, (vecs[i].exp_plots > 0) ? 2 : -1);
            check({tag, " busy cycles"}, busy_n, vecs[i].exp_done);
            check({tag, " busy at done"}, int'(busy), 0);
            exp_q.delete();
            tick();
            check({tag, " done pulse width"}, int'(done), 0);
        end

        // Outline interior pixels are scanned with plot low.
        begin
            vec_t v;
            v = vecs[4];
            mode = v.mode; x0 = '0; y0 = '0; width = 11'd4; height = 10'd3;
            color = v.color; start = 1'b1;
            tick();
            start = 1'b0;
            repeat (7) tick();  // pixel index 5 = (1,1) visible after edge k+7
            check("outline (1,1) x", int'(vga_x), 1);
            check("outline (1,1) y", int'(vga_y), 1);
            check("outline (1,1) plot", int'(plot), 0);
            tick();
            check("outline (2,1) x", int'(vga_x), 2);
            check("outline (2,1) y", int'(vga_y), 1);
            check("outline (2,1) plot", int'(plot), 0);
            repeat (20) tick();
            check("outline idle again", int'(busy), 0);
        end

        // Stray start during the draw is dropped.
        run_cmd(vecs[0], 1, "stray start", done_at, plots, first, busy_n);
        check("stray start done cycle", done_at, 8);
        check("stray start plot count", plots, 6);
        check("stray start pixels left", exp_q.size(), 0);
        exp_q.delete();
        watch_idle(15, act);
        check("stray start not queued", act, 0);

        // Reset mid-draw: two pixels out, four never drawn, no done.
        run_cmd(vecs[0], 2, "mid reset", done_at, plots, first, busy_n);
        check("mid reset plots before", plots, 2);
        check("mid reset pixels dropped", exp_q.size(), 4);
        check("mid reset no done", done_at, -1);
        exp_q.delete();
        watch_idle(15, act);
        check("mid reset stays idle", act, 0);

        // Fresh command after reset.
        run_cmd(vecs[0], 0, "after reset", done_at, plots, first, busy_n);
        check("after reset done cycle", done_at, 8);
        check("after reset plot count", plots, 6);
        check("after reset pixels left", exp_q.size(), 0);
        exp_q.delete();

        // Clear screen on the small instance; position and size inputs are ignored.
        begin
            bit covered [SH*SV];
            int n, dup, oob, badc, last_x, last_y, s_done_at, missing;
            n = 0; dup = 0; oob = 0; badc = 0; last_x = -1; last_y = -1;
            s_done_at = -1; missing = 0;
            for (int i = 0; i < SH*SV; i++) covered[i] = 1'b0;
            s_mode = 2'd1; s_x0 = 8'd50; s_y0 = 7'd7; s_width = 9'd3;
            s_height = 8'd2; s_color = 3'b001; s_start = 1'b1;
            tick();
            s_start = 1'b0;
            for (int c = 0; c <= SH*SV + 20; c++) begin
                if (c > 0) tick();
                if (s_plot) begin
                    if (int'(s_vga_x) < SH && int'(s_vga_y) < SV) begin
                        if (covered[int'(s_vga_y)*SH + int'(s_vga_x)]) dup++;
                        covered[int'(s_vga_y)*SH + int'(s_vga_x)] = 1'b1;
                    end else begin
                        oob++;
                    end
                    if (s_vga_color != 3'b001) badc++;
                    n++;
                    last_x = int'(s_vga_x);
                    last_y = int'(s_vga_y);
                end
                if (s_done) begin
                    s_done_at = c;
                    break;
                end
            end
            for (int i = 0; i < SH*SV; i++) if (!covered[i]) missing++;
            check("clear plot count", n, SH*SV);
            check("clear duplicates", dup, 0);
            check("clear off screen", oob, 0);
            check("clear wrong colour", badc, 0);
            check("clear missing pixels", missing, 0);
            check("clear last x", last_x, SH-1);
            check("clear last y", last_y, SV-1);
            check("clear done cycle", s_done_at, SH*SV + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
